// File: rtl/rcv_frame_sr.sv
// rcv_frame_sr: parametrised serial-receive frame shift register with capture, parity/stop check and read handshake
`timescale 1ns/1ps
module rcv_frame_sr #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int MSB_FIRST  = 0,
  localparam int FB = DATA_BITS + PARITY_EN + 1,
  localparam int CW = $clog2(FB + 1)
) (
  input  logic                 clk_i,
  input  logic                 n_rst_i,
  input  logic                 frame_start_i,
  input  logic                 shift_strobe_i,
  input  logic                 serial_in_i,
  input  logic                 data_read_i,
  output logic [DATA_BITS-1:0] packet_data_o,
  output logic                 stop_bit_o,
  output logic                 parity_error_o,
  output logic                 framing_error_o,
  output logic                 overrun_error_o,
  output logic                 data_ready_o,
  output logic [CW-1:0]        bit_count_o
);
  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;
  state_t state_q, state_d;
  logic [FB-1:0]        sr_q, sr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] pkt_q, pkt_d, data_w;
  logic                 stop_q, stop_d, perr_q, perr_d, ferr_q, ferr_d;
  logic                 ovr_q, ovr_d, rdy_q, rdy_d;
  // data field of the shift register in output bit order
  always_comb
    for (int i = 0; i < DATA_BITS; i++)
      data_w[i] = (MSB_FIRST != 0) ? sr_q[DATA_BITS-1-i] : sr_q[i];
  // all state registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge n_rst_i)
    if (!n_rst_i) begin
      state_q <= IDLE;
      sr_q    <= '1;
      cnt_q   <= '0;
      pkt_q   <= '1;
      stop_q  <= 1'b1;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      pkt_q   <= pkt_d;
      stop_q  <= stop_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      rdy_q   <= rdy_d;
    end
  // next state: frame_start always beats a coincident strobe; capture happens in the single LOAD cycle
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    pkt_d   = pkt_q;
    stop_d  = stop_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    rdy_d   = rdy_q;
    case (state_q)
      IDLE: if (frame_start_i) begin
        state_d = SHIFT;
        cnt_d   = '0;
      end
      SHIFT: if (frame_start_i) cnt_d = '0;
        else if (shift_strobe_i) begin
          sr_d  = {serial_in_i, sr_q[FB-1:1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(FB - 1)) state_d = LOAD;
        end
      default: begin
        state_d = frame_start_i ? SHIFT : IDLE;
        cnt_d   = '0;
        pkt_d   = data_w;
        stop_d  = sr_q[FB-1];
        ferr_d  = ~sr_q[FB-1];
        perr_d  = (PARITY_EN != 0) & ((^sr_q[DATA_BITS:0]) ^ (PARITY_ODD != 0));
      end
    endcase
    if (state_q == LOAD) begin
      rdy_d = 1'b1;
      if (rdy_q && !data_read_i) ovr_d = 1'b1;
    end else if (data_read_i && rdy_q) begin
      rdy_d = 1'b0;
      ovr_d = 1'b0;
    end
  end
  assign packet_data_o   = pkt_q;
  assign stop_bit_o      = stop_q;
  assign parity_error_o  = perr_q;
  assign framing_error_o = ferr_q;
  assign overrun_error_o = ovr_q;
  assign data_ready_o    = rdy_q;
  assign bit_count_o     = cnt_q;
endmodule

// File: tb/tb_rcv_frame_sr.sv
// tb_rcv_frame_sr: directed self-checking bench for rcv_frame_sr (default, parity and MSB-first instances)
`timescale 1ns/1ps
module tb_rcv_frame_sr;
  logic clk = 1'b0, n_rst = 1'b0, fs = 1'b0, ss = 1'b0, si = 1'b1, dr = 1'b0;
  logic [7:0] pkt, pkt_p, pkt_m;
  logic stop, perr, ferr, ovr, rdy, stop_p, perr_p, ferr_p, ovr_p, rdy_p, stop_m, perr_m, ferr_m, ovr_m, rdy_m;
  logic [3:0] cnt, cnt_p, cnt_m;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  rcv_frame_sr u_dut (.clk_i(clk), .n_rst_i(n_rst), .frame_start_i(fs), .shift_strobe_i(ss), .serial_in_i(si),
    .data_read_i(dr), .packet_data_o(pkt), .stop_bit_o(stop), .parity_error_o(perr), .framing_error_o(ferr),
    .overrun_error_o(ovr), .data_ready_o(rdy), .bit_count_o(cnt));
  rcv_frame_sr #(.PARITY_EN(1), .PARITY_ODD(0)) u_par (.clk_i(clk), .n_rst_i(n_rst), .frame_start_i(fs),
    .shift_strobe_i(ss), .serial_in_i(si), .data_read_i(dr), .packet_data_o(pkt_p), .stop_bit_o(stop_p),
    .parity_error_o(perr_p), .framing_error_o(ferr_p), .overrun_error_o(ovr_p), .data_ready_o(rdy_p),
    .bit_count_o(cnt_p));
  rcv_frame_sr #(.MSB_FIRST(1)) u_msb (.clk_i(clk), .n_rst_i(n_rst), .frame_start_i(fs), .shift_strobe_i(ss),
    .serial_in_i(si), .data_read_i(dr), .packet_data_o(pkt_m), .stop_bit_o(stop_m), .parity_error_o(perr_m),
    .framing_error_o(ferr_m), .overrun_error_o(ovr_m), .data_ready_o(rdy_m), .bit_count_o(cnt_m));

  task automatic start_frame();
    @(negedge clk) fs = 1'b1;
    @(negedge clk) fs = 1'b0;
  endtask

  task automatic shift_bits(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ss = 1'b1;
      si = bits[i];
      @(negedge clk);
    end
    ss = 1'b0;
    si = 1'b1;
  endtask

  task automatic send_frame(input logic [15:0] bits, input int n);
    start_frame();
    shift_bits(bits, n);
    @(negedge clk);
  endtask

  task automatic read_pulse();
    dr = 1'b1;
    @(negedge clk) dr = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    si = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk) ss = ~ss;
      fs = (i == 2);
    end
    fs = 1'b0;
    ss = 1'b0;
    tests++; if (pkt !== 8'hFF) begin fails++; $display("FAIL reset_pkt got %h want ff", pkt); end
    tests++; if (stop !== 1'b1) begin fails++; $display("FAIL reset_stop got %b want 1", stop); end
    tests++; if (rdy !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", rdy); end
    tests++; if (cnt !== 4'd0) begin fails++; $display("FAIL reset_count got %0d want 0", cnt); end
    tests++; if ({perr, ferr, ovr} !== 3'b000) begin fails++; $display("FAIL reset_errs got %b want 000", {perr, ferr, ovr}); end
    si = 1'b1;
    @(negedge clk) n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_default_frame();
    send_frame(16'h01A5, 9);
    tests++; if (pkt !== 8'hA5) begin fails++; $display("FAIL dflt_pkt got %h want a5", pkt); end
    tests++; if (stop !== 1'b1) begin fails++; $display("FAIL dflt_stop got %b want 1", stop); end
    tests++; if (ferr !== 1'b0) begin fails++; $display("FAIL dflt_ferr got %b want 0", ferr); end
    tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL dflt_ready got %b want 1", rdy); end
    tests++; if (cnt !== 4'd0) begin fails++; $display("FAIL dflt_count got %0d want 0", cnt); end
    read_pulse();
    tests++; if (rdy !== 1'b0) begin fails++; $display("FAIL dflt_read got %b want 0", rdy); end
    tests++; if (pkt !== 8'hA5) begin fails++; $display("FAIL dflt_hold got %h want a5", pkt); end
  endtask

  task automatic test_parity();
    send_frame(16'h0303, 10);
    tests++; if (pkt_p !== 8'h03) begin fails++; $display("FAIL par_pkt got %h want 03", pkt_p); end
    tests++; if (perr_p !== 1'b1) begin fails++; $display("FAIL par_err1 got %b want 1", perr_p); end
    tests++; if (perr !== 1'b0) begin fails++; $display("FAIL par_off got %b want 0", perr); end
    send_frame(16'h0203, 10);
    tests++; if (perr_p !== 1'b0) begin fails++; $display("FAIL par_err0 got %b want 0", perr_p); end
    tests++; if (rdy_p !== 1'b1) begin fails++; $display("FAIL par_ready got %b want 1", rdy_p); end
    read_pulse();
  endtask

  task automatic test_framing();
    send_frame(16'h005A, 9);
    tests++; if (pkt !== 8'h5A) begin fails++; $display("FAIL frm_pkt got %h want 5a", pkt); end
    tests++; if (ferr !== 1'b1) begin fails++; $display("FAIL frm_err got %b want 1", ferr); end
    tests++; if (stop !== 1'b0) begin fails++; $display("FAIL frm_stop got %b want 0", stop); end
    tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL frm_ready got %b want 1", rdy); end
    read_pulse();
    tests++; if (ferr !== 1'b1) begin fails++; $display("FAIL frm_hold got %b want 1", ferr); end
  endtask

  task automatic test_overrun();
    send_frame(16'h0111, 9);
    tests++; if (ovr !== 1'b0) begin fails++; $display("FAIL ovr_first got %b want 0", ovr); end
    send_frame(16'h0122, 9);
    tests++; if (pkt !== 8'h22) begin fails++; $display("FAIL ovr_pkt got %h want 22", pkt); end
    tests++; if (ovr !== 1'b1) begin fails++; $display("FAIL ovr_flag got %b want 1", ovr); end
    tests++; if (ferr !== 1'b0) begin fails++; $display("FAIL ovr_ferr got %b want 0", ferr); end
    tests++; if (pkt_m !== 8'h44) begin fails++; $display("FAIL msb_pkt got %h want 44", pkt_m); end
    read_pulse();
    tests++; if (rdy !== 1'b0) begin fails++; $display("FAIL ovr_read_rdy got %b want 0", rdy); end
    tests++; if (ovr !== 1'b0) begin fails++; $display("FAIL ovr_read_ovr got %b want 0", ovr); end
  endtask

  task automatic test_abort();
    start_frame();
    shift_bits(16'h000F, 4);
    tests++; if (cnt !== 4'd4) begin fails++; $display("FAIL abort_cnt4 got %0d want 4", cnt); end
    start_frame();
    tests++; if (cnt !== 4'd0) begin fails++; $display("FAIL abort_cnt0 got %0d want 0", cnt); end
    shift_bits(16'h013C, 9);
    @(negedge clk);
    tests++; if (pkt !== 8'h3C) begin fails++; $display("FAIL abort_pkt got %h want 3c", pkt); end
    read_pulse();
  endtask

  task automatic test_coincident();
    start_frame();
    shift_bits(16'h0007, 3);
    @(negedge clk) begin fs = 1'b1; ss = 1'b1; si = 1'b0; end
    @(negedge clk) begin fs = 1'b0; ss = 1'b0; si = 1'b1; end
    tests++; if (cnt !== 4'd0) begin fails++; $display("FAIL coin_cnt got %0d want 0", cnt); end
    shift_bits(16'h01C3, 9);
    @(negedge clk);
    tests++; if (pkt !== 8'hC3) begin fails++; $display("FAIL coin_pkt got %h want c3", pkt); end
    tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL coin_ready got %b want 1", rdy); end
    read_pulse();
  endtask

  task automatic test_reset_mid_frame();
    send_frame(16'h0166, 9);
    start_frame();
    shift_bits(16'h001F, 5);
    #2 n_rst = 1'b0;
    #1;
    tests++; if (cnt !== 4'd0) begin fails++; $display("FAIL rstmid_cnt got %0d want 0", cnt); end
    tests++; if (pkt !== 8'hFF) begin fails++; $display("FAIL rstmid_pkt got %h want ff", pkt); end
    tests++; if (rdy !== 1'b0) begin fails++; $display("FAIL rstmid_ready got %b want 0", rdy); end
    @(negedge clk) n_rst = 1'b1;
    shift_bits(16'h000F, 4);
    @(negedge clk);
    tests++; if (rdy !== 1'b0) begin fails++; $display("FAIL rstmid_nocap got %b want 0", rdy); end
    tests++; if (pkt !== 8'hFF) begin fails++; $display("FAIL rstmid_keep got %h want ff", pkt); end
  endtask

  initial begin
    test_reset();
    test_default_frame();
    test_parity();
    test_framing();
    test_overrun();
    test_abort();
    test_coincident();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
